// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - elaboration-time helpers for the serial pattern detector
package seq_det_pkg;

    localparam int PW_MAX = 16;
    localparam int NXT_W  = 4;

    typedef logic [PW_MAX*2*NXT_W-1:0] nxt_tbl_t;

    // Entry (p*2+x) holds the longest pattern prefix (< width) that is a suffix
    // of "first p pattern bits followed by x"; pattern[width-1] is received first.
    function automatic nxt_tbl_t build_nxt(input logic [PW_MAX-1:0] pattern, input int width);
        nxt_tbl_t tbl;
        int       best;
        int       si;
        logic     ok;
        logic     sb;
        tbl = '0;
        for (int p = 0; p < width; p++) begin
            for (int xb = 0; xb < 2; xb++) begin
                best = 0;
                for (int k = 1; (k <= p + 1) && (k < width); k++) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        si = p + 1 - k + j;
                        sb = (si == p) ? (xb != 0) : pattern[width-1-si];
                        if (sb != pattern[width-1-j]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
                tbl[(p*2+xb)*NXT_W +: NXT_W] = NXT_W'(best);
            end
        end
        return tbl;
    endfunction

    function automatic int fail_len(input logic [PW_MAX-1:0] pattern, input int width);
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k < width; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pattern[width-1-j] != pattern[k-1-j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with clear and sticky saturation flag
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_FULL = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_full;
    logic             w_almost;

    assign w_full   = (r_cnt == LP_FULL);
    assign w_almost = (r_cnt == (LP_FULL - LP_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            // a match landing on the clear cycle is the first of the new count
            r_cnt <= i_inc ? LP_ONE : '0;
            r_sat <= 1'b0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + LP_ONE;
            if (w_almost) r_sat <= 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy serial pattern detector with match counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110101,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     x,
    input  logic                     overlap,
    input  logic                     clr_cnt,
    output logic                     y,
    output logic                     y_q,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat,
    output logic [$clog2(PAT_W)-1:0] progress
);

    localparam int               PW      = $clog2(PAT_W);
    localparam logic [PW_MAX-1:0] LP_PAT = PW_MAX'(PATTERN);
    localparam nxt_tbl_t         LP_NXT  = build_nxt(LP_PAT, PAT_W);
    localparam logic [PW-1:0]    LP_FAIL = PW'(fail_len(LP_PAT, PAT_W));
    localparam logic [PW-1:0]    LP_LAST = PW'(PAT_W - 1);

    if (PAT_W < 2 || PAT_W > PW_MAX) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W must be in 2..16");
    end

    logic [PW-1:0] w_tbl [2*PAT_W];
    logic [PW-1:0] r_p;
    logic [PW-1:0] w_p_next;
    logic          w_y;
    logic          r_y_q;

    for (genvar gi = 0; gi < 2 * PAT_W; gi++) begin : g_tbl
        assign w_tbl[gi] = LP_NXT[gi*NXT_W +: PW];
    end

    assign w_y = en & ~rst & (r_p == LP_LAST) & (x == PATTERN[0]);

    always_comb begin
        w_p_next = r_p;
        if (en) begin
            if (w_y) w_p_next = overlap ? LP_FAIL : '0;
            else     w_p_next = w_tbl[{r_p, x}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= '0;
            r_y_q <= 1'b0;
        end else begin
            r_p   <= w_p_next;
            r_y_q <= w_y;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_y),
        .i_clr (clr_cnt),
        .o_cnt (match_cnt),
        .o_sat (cnt_sat)
    );

    assign y        = w_y;
    assign y_q      = r_y_q;
    assign progress = r_p;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst, en, x, overlap, clr_cnt;

    logic       y0, yq0, sat0;
    logic [7:0] cnt0;
    logic [2:0] prog0;
    logic       y2, yq2, sat2;
    logic [1:0] cnt2;
    logic [2:0] prog2;
    logic       y4, yq4, sat4;
    logic [7:0] cnt4;
    logic [1:0] prog4;

    always #5 clk = ~clk;

    seq_detector_param u_dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y0), .y_q(yq0), .match_cnt(cnt0), .cnt_sat(sat0), .progress(prog0)
    );

    seq_detector_param #(.PAT_W(6), .PATTERN(6'b110101), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y2), .y_q(yq2), .match_cnt(cnt2), .cnt_sat(sat2), .progress(prog2)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y4), .y_q(yq4), .match_cnt(cnt4), .cnt_sat(sat4), .progress(prog4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: history of accepted bits, matches found by direct comparison.
    int          m_pat [3] = '{53, 53, 15};
    int          m_pw  [3] = '{6, 6, 4};
    int          m_max [3] = '{255, 3, 255};
    logic [31:0] m_h   [3];
    int          m_hl  [3];
    int          m_cnt [3];
    bit          m_sat [3];
    bit          m_yq  [3];
    logic        ly    [3];

    function automatic bit m_match(int i, int xi);
        logic [31:0] h2;
        logic [31:0] mask;
        h2   = (m_h[i] << 1) | 32'(xi != 0);
        mask = (32'd1 << m_pw[i]) - 32'd1;
        return (m_hl[i] + 1 >= m_pw[i]) && ((h2 & mask) == 32'(m_pat[i]));
    endfunction

    function automatic int m_prog(int i);
        logic [31:0] mask;
        for (int k = m_pw[i] - 1; k > 0; k--) begin
            mask = (32'd1 << k) - 32'd1;
            if (k <= m_hl[i] && (m_h[i] & mask) == 32'(m_pat[i] >> (m_pw[i] - k))) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int xi, input int ei, input int ri, input int oi, input int ci);
        bit m [3];
        x = (xi != 0); en = (ei != 0); rst = (ri != 0); overlap = (oi != 0); clr_cnt = (ci != 0);
        #1;
        for (int i = 0; i < 3; i++) m[i] = (ei != 0) && (ri == 0) && m_match(i, xi);
        ly[0] = y0; ly[1] = y2; ly[2] = y4;
        chk("y0", 32'(y0), 32'(m[0]));
        chk("y2", 32'(y2), 32'(m[1]));
        chk("y4", 32'(y4), 32'(m[2]));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (ri != 0) begin
                m_h[i] = '0; m_hl[i] = 0; m_yq[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
            end else begin
                m_yq[i] = m[i];
                if (ei != 0) begin
                    m_h[i]  = (m_h[i] << 1) | 32'(xi != 0);
                    m_hl[i] = (m_hl[i] < 64) ? m_hl[i] + 1 : 64;
                    if (m[i] && oi == 0) begin m_h[i] = '0; m_hl[i] = 0; end
                end
                if (ci != 0) begin
                    m_cnt[i] = m[i] ? 1 : 0; m_sat[i] = 0;
                end else if (m[i] && m_cnt[i] != m_max[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_max[i]) m_sat[i] = 1;
                end
            end
        end
        #1;
        chk("yq0", 32'(yq0), 32'(m_yq[0]));   chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("sat0", 32'(sat0), 32'(m_sat[0])); chk("prog0", 32'(prog0), 32'(m_prog(0)));
        chk("yq2", 32'(yq2), 32'(m_yq[1]));   chk("cnt2", 32'(cnt2), 32'(m_cnt[1]));
        chk("sat2", 32'(sat2), 32'(m_sat[1])); chk("prog2", 32'(prog2), 32'(m_prog(1)));
        chk("yq4", 32'(yq4), 32'(m_yq[2]));   chk("cnt4", 32'(cnt4), 32'(m_cnt[2]));
        chk("sat4", 32'(sat4), 32'(m_sat[2])); chk("prog4", 32'(prog4), 32'(m_prog(2)));
        @(negedge clk);
    endtask

    task automatic send(input int bits [$], input int ov, inout logic [31:0] pos0, inout logic [31:0] pos4);
        for (int k = 0; k < bits.size(); k++) begin
            step(bits[k], 1, 0, ov, 0);
            if (ly[0] === 1'b1) pos0 |= (32'd1 << k);
            if (ly[2] === 1'b1) pos4 |= (32'd1 << k);
        end
    endtask

    initial begin
        int          s1 [$];
        int          p6 [$];
        int          ones [$];
        logic [31:0] pos0, pos4;
        int          pi, ov, xi;
        int          exp5 [4];

        s1   = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
        p6   = '{1, 1, 0, 1, 0, 1};
        ones = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp5 = '{1, 2, 3, 3};
        for (int i = 0; i < 3; i++) begin
            m_h[i] = '0; m_hl[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_yq[i] = 0;
        end

        step(1, 1, 1, 1, 0);
        chk("rst_prog", 32'(prog0), 32'd0); chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_yq", 32'(yq0), 32'd0);     chk("rst_sat", 32'(sat0), 32'd0);

        // stream with overlap: matches on bits 6 and 11
        pos0 = '0; pos4 = '0;
        send(s1, 1, pos0, pos4);
        chk("t1_ypos", pos0, 32'h420);
        chk("t1_cnt", 32'(cnt0), 32'd2);

        step(0, 0, 1, 0, 0);
        pos0 = '0; pos4 = '0;
        send(s1, 0, pos0, pos4);
        chk("t2_ypos", pos0, 32'h020);
        chk("t2_cnt", 32'(cnt0), 32'd1);
        chk("t2_prog", 32'(prog0), 32'd1);

        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(k % 2, 0, 0, k % 2, 0);
        chk("t3_hold", 32'(prog0), 32'd3);
        step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
        chk("t3_y", 32'(ly[0]), 32'd1);

        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("t4_rst_y", 32'(ly[0]), 32'd0);
        step(1, 1, 0, 1, 0);
        chk("t4_y", 32'(ly[0]), 32'd0);
        chk("t4_prog", 32'(prog0), 32'd1);
        chk("t4_cnt", 32'(cnt0), 32'd0);

        step(0, 0, 1, 0, 0);
        for (int n = 0; n < 4; n++) begin
            send(p6, 0, pos0, pos4);
            chk("t5_cnt", 32'(cnt2), 32'(exp5[n]));
            if (n == 2) chk("t5_sat", 32'(sat2), 32'd1);
        end
        for (int k = 0; k < 5; k++) step(p6[k], 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("t5_clr_cnt", 32'(cnt2), 32'd1);
        chk("t5_clr_sat", 32'(sat2), 32'd0);

        step(0, 0, 1, 0, 0);
        pos0 = '0; pos4 = '0;
        send(ones, 1, pos0, pos4);
        chk("t6_ov_ypos", pos4, 32'h0F8);
        chk("t6_ov_cnt", 32'(cnt4), 32'd5);
        step(0, 0, 1, 0, 0);
        pos0 = '0; pos4 = '0;
        send(ones, 0, pos0, pos4);
        chk("t6_nov_ypos", pos4, 32'h088);
        chk("t6_nov_cnt", 32'(cnt4), 32'd2);

        // randomised traffic biased towards the 110101 pattern
        step(0, 0, 1, 0, 0);
        pi = 0; ov = 1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(15) == 0) ov = 1 - ov;
            xi = ($urandom_range(3) == 0) ? int'($urandom_range(1)) : p6[pi];
            if ($urandom_range(7) != 0) begin
                step(xi, 1, ($urandom_range(99) == 0) ? 1 : 0, ov, ($urandom_range(40) == 0) ? 1 : 0);
                pi = (pi + 1) % 6;
            end else begin
                step(xi, 0, 0, ov, ($urandom_range(40) == 0) ? 1 : 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
